// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: sequencer state encoding,
// default operand width and the {HI,LO} field offsets of the packed result.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam int LO_LSB = 0;
  localparam int LO_MSB = DIV_WIDTH - 1;
  localparam int HI_LSB = DIV_WIDTH;
  localparam int HI_MSB = 2 * DIV_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    DZERO = 2'd2,
    END   = 2'd3
  } divState_t;

endpackage

// File: rtl/div_if.sv
// Execute-stage handshake between the pipeline control and the divider.
// The pipeline side drives through master; the divider sits on slave.
interface div_if #(
  parameter int WIDTH = div_pkg::DIV_WIDTH
);

  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               annul_i;
  logic               advance_i;
  logic               stall_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i, advance_i,
    input  stall_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i, advance_i,
    output stall_o, ready_o, result_o
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and keep
// the trial difference only when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic             bitIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic             qBit
);

  logic [WIDTH:0] shifted;

  assign shifted = {remIn, bitIn};
  assign qBit    = (shifted >= {1'b0, divisor});
  // A kept difference is below the divisor, so WIDTH bits hold it exactly.
  assign remOut  = qBit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider and sequencer for DIV/DIVU in the E stage.
// Optional macro DIV_SHORTCUT_EN: |divisor| > |dividend| skips the iterations.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  divState_t          stateReg, stateNext;
  logic [WIDTH-1:0]   shiftReg;
  logic [WIDTH-1:0]   divisorReg;
  logic [WIDTH-1:0]   remReg;
  logic [WIDTH-1:0]   origReg;
  logic [CNT_W-1:0]   cntReg;
  logic               qSignReg;
  logic               rSignReg;
  logic [2*WIDTH-1:0] resultReg;

  logic             accept;
  logic             lastIter;
  logic             dividendNeg;
  logic             divisorNeg;
  logic [WIDTH-1:0] absDividend;
  logic [WIDTH-1:0] absDivisor;
  logic [WIDTH-1:0] stepRem;
  logic             stepBit;
  logic [WIDTH-1:0] finalQuot;
  logic [WIDTH-1:0] fixQuot;
  logic [WIDTH-1:0] fixRem;
  logic             stall;

`ifdef DIV_SHORTCUT_EN
  logic shortcutReg;
  logic takeShort;
  assign takeShort = (absDivisor > absDividend);
`endif

  assign accept      = (stateReg == IDLE) && bus.start_i && !bus.annul_i;
  assign dividendNeg = bus.signed_i & bus.opdata1_i[WIDTH-1];
  assign divisorNeg  = bus.signed_i & bus.opdata2_i[WIDTH-1];
  assign absDividend = dividendNeg ? -bus.opdata1_i : bus.opdata1_i;
  assign absDivisor  = divisorNeg  ? -bus.opdata2_i : bus.opdata2_i;
  assign lastIter    = (cntReg == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .remIn   (remReg),
    .bitIn   (shiftReg[WIDTH-1]),
    .divisor (divisorReg),
    .remOut  (stepRem),
    .qBit    (stepBit)
  );

  // shiftReg feeds dividend bits out of the top while quotient bits fill
  // the bottom, so on the last iteration it plus stepBit is the quotient.
  assign finalQuot = {shiftReg[WIDTH-2:0], stepBit};
  assign fixQuot   = qSignReg ? -finalQuot : finalQuot;
  assign fixRem    = rSignReg ? -stepRem : stepRem;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    stall     = 1'b0;
    case (stateReg)
      IDLE: begin
        if (accept) begin
          stall = 1'b1;
          if (bus.opdata2_i == '0) begin
            stateNext = DZERO;
`ifdef DIV_SHORTCUT_EN
          end else if (takeShort) begin
            // Routed through DZERO so the early result keeps the 2-cycle timing.
            stateNext = DZERO;
`endif
          end else begin
            stateNext = ON;
          end
        end
      end
      ON: begin
        stall = 1'b1;
        if (bus.annul_i) begin
          stateNext = IDLE;
        end else if (lastIter) begin
          stateNext = END;
        end
      end
      DZERO: begin
        stall     = 1'b1;
        stateNext = bus.annul_i ? IDLE : END;
      end
      END: begin
        if (bus.annul_i || bus.advance_i) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shiftReg   <= '0;
      divisorReg <= '0;
      remReg     <= '0;
      origReg    <= '0;
      cntReg     <= '0;
      qSignReg   <= 1'b0;
      rSignReg   <= 1'b0;
      resultReg  <= '0;
`ifdef DIV_SHORTCUT_EN
      shortcutReg <= 1'b0;
`endif
    end else begin
      case (stateReg)
        IDLE: begin
          if (accept) begin
            shiftReg   <= absDividend;
            divisorReg <= absDivisor;
            origReg    <= bus.opdata1_i;
            remReg     <= '0;
            cntReg     <= '0;
            qSignReg   <= dividendNeg ^ divisorNeg;
            rSignReg   <= dividendNeg;
`ifdef DIV_SHORTCUT_EN
            shortcutReg <= (bus.opdata2_i != '0);
`endif
          end
        end
        ON: begin
          if (!bus.annul_i) begin
            shiftReg <= finalQuot;
            remReg   <= stepRem;
            cntReg   <= cntReg + CNT_W'(1);
            if (lastIter) begin
              resultReg <= {fixRem, fixQuot};
            end
          end
        end
        DZERO: begin
          if (!bus.annul_i) begin
`ifdef DIV_SHORTCUT_EN
            resultReg <= {origReg, shortcutReg ? {WIDTH{1'b0}} : {WIDTH{1'b1}}};
`else
            resultReg <= {origReg, {WIDTH{1'b1}}};
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_o  = stall;
  assign bus.ready_o  = (stateReg == END);
  assign bus.result_o = resultReg;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: expected {HI,LO} values are queued at stimulus
// time and compared when ready_o rises; latency and stall windows are counted.
module tb_div_seq;
  import div_pkg::*;

  localparam int W = DIV_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_if #(.WIDTH(W)) bus ();

  div_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passCount  = 0;
  int totalCount = 0;
  logic [2*W-1:0] sbQ[$];
  logic [2*W-1:0] lastResult = '0;

  function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ua, ub, q, r;
    logic na, nb;
    if (b == '0) return {a, {W{1'b1}}};
    na = sgn & a[W-1];
    nb = sgn & b[W-1];
    ua = na ? (~a + 1) : a;
    ub = nb ? (~b + 1) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (na ^ nb) q = ~q + 1;
    if (na) r = ~r + 1;
    return {r, q};
  endfunction

  function automatic int expLatency(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ua, ub;
    if (b == '0) return 2;
    ua = (sgn && a[W-1]) ? (~a + 1) : a;
    ub = (sgn && b[W-1]) ? (~b + 1) : b;
`ifdef DIV_SHORTCUT_EN
    if (ub > ua) return 2;
`endif
    if (ub > ua) return W + 1;
    return W + 1;
  endfunction

  // Starts a divide in cycle 0 and watches until ready_o or the cycle budget.
  task automatic do_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int annulAt, input int maxCycles,
                        output int readyCycle, output int stallLow);
    readyCycle = -1;
    stallLow   = -1;
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.signed_i  = sgn;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.advance_i = 1'b0;
    bus.annul_i   = 1'b0;
    #1;
    if (!bus.stall_o) stallLow = 0;
    for (int c = 1; c <= maxCycles; c++) begin
      @(negedge clk);
      if (!bus.stall_o && stallLow < 0) stallLow = c;
      if (bus.ready_o) begin
        readyCycle = c;
        break;
      end
      bus.start_i = 1'b0;
      bus.annul_i = (c == annulAt);
    end
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    $display("div signed=%0d a=%h b=%h ready_cycle=%0d stall_low=%0d result=%h",
             sgn, a, b, readyCycle, stallLow, bus.result_o);
  endtask

  task automatic release_result();
    bus.advance_i = 1'b1;
    @(negedge clk);
    bus.advance_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    totalCount++;
    if (bus.ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.ready_o);
    else passCount++;
    totalCount++;
    if (bus.result_o !== '0) $display("FAIL reset_result: got %h want 0", bus.result_o);
    else passCount++;
    rst = 1'b0;
    @(negedge clk);
    totalCount++;
    if (bus.stall_o !== 1'b0) $display("FAIL reset_idle_stall: got %b want 0", bus.stall_o);
    else passCount++;
  endtask

  task automatic test_divu_basic();
    int rc, sl;
    logic [2*W-1:0] exp;
    sbQ.push_back(model(1'b0, 32'd100, 32'd7));
    do_div(1'b0, 32'd100, 32'd7, -1, 60, rc, sl);
    totalCount++;
    if (rc !== 33) $display("FAIL divu_latency: got %0d want 33", rc);
    else passCount++;
    totalCount++;
    if (sl !== 33) $display("FAIL divu_stall_window: stall first low at %0d want 33", sl);
    else passCount++;
    exp = sbQ.pop_front();
    lastResult = exp;
    totalCount++;
    if (bus.result_o !== exp) $display("FAIL divu_result_sb: got %h want %h", bus.result_o, exp);
    else passCount++;
    totalCount++;
    if (bus.result_o !== {32'd2, 32'd14}) $display("FAIL divu_result_const: got %h want %h", bus.result_o, {32'd2, 32'd14});
    else passCount++;
    bus.advance_i = 1'b1;
    @(negedge clk);
    bus.advance_i = 1'b0;
    totalCount++;
    if (bus.ready_o !== 1'b0 || bus.stall_o !== 1'b0)
      $display("FAIL divu_advance_idle: ready=%b stall=%b want 0 0", bus.ready_o, bus.stall_o);
    else passCount++;
  endtask

  task automatic test_signed();
    logic [W-1:0] aTab[5];
    logic [W-1:0] bTab[5];
    logic [2*W-1:0] exp;
    int rc, sl;
    aTab[0] = 32'hFFFF_FFF9;  bTab[0] = 32'd2;
    aTab[1] = 32'h8000_0000;  bTab[1] = 32'hFFFF_FFFF;
    for (int i = 2; i < 5; i++) begin
      aTab[i] = $urandom;
      bTab[i] = $urandom_range(1, 5000) * (i[0] ? 1 : -1);
    end
    for (int i = 0; i < 5; i++) begin
      sbQ.push_back(model(1'b1, aTab[i], bTab[i]));
      do_div(1'b1, aTab[i], bTab[i], -1, 60, rc, sl);
      totalCount++;
      if (rc !== expLatency(1'b1, aTab[i], bTab[i]))
        $display("FAIL signed_latency[%0d]: got %0d want %0d", i, rc, expLatency(1'b1, aTab[i], bTab[i]));
      else passCount++;
      exp = sbQ.pop_front();
      lastResult = exp;
      totalCount++;
      if (bus.result_o !== exp) $display("FAIL signed_result[%0d]: got %h want %h", i, bus.result_o, exp);
      else passCount++;
      if (i == 0) begin
        totalCount++;
        if (bus.result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD})
          $display("FAIL signed_m7_2: got %h want ffffffff_fffffffd", bus.result_o);
        else passCount++;
      end
      if (i == 1) begin
        totalCount++;
        if (bus.result_o !== {32'h0, 32'h8000_0000})
          $display("FAIL signed_minint_m1: got %h want 00000000_80000000", bus.result_o);
        else passCount++;
      end
      release_result();
    end
  endtask

  task automatic test_div_zero();
    int rc, sl;
    logic [2*W-1:0] exp;
    sbQ.push_back(model(1'b0, 32'd5, 32'd0));
    do_div(1'b0, 32'd5, 32'd0, -1, 60, rc, sl);
    totalCount++;
    if (rc !== 2) $display("FAIL dzero_latency: got %0d want 2", rc);
    else passCount++;
    totalCount++;
    if (sl !== 2) $display("FAIL dzero_stall_window: stall first low at %0d want 2", sl);
    else passCount++;
    exp = sbQ.pop_front();
    totalCount++;
    if (bus.result_o !== {32'd5, 32'hFFFF_FFFF}) $display("FAIL dzero_result: got %h want 00000005_ffffffff", bus.result_o);
    else passCount++;
    totalCount++;
    if (bus.result_o !== exp) $display("FAIL dzero_result_sb: got %h want %h", bus.result_o, exp);
    else passCount++;
    release_result();
    sbQ.push_back(model(1'b1, 32'hFFFF_FFFB, 32'd0));
    do_div(1'b1, 32'hFFFF_FFFB, 32'd0, -1, 60, rc, sl);
    exp = sbQ.pop_front();
    lastResult = exp;
    totalCount++;
    if (bus.result_o !== {32'hFFFF_FFFB, 32'hFFFF_FFFF}) $display("FAIL dzero_signed: got %h want fffffffb_ffffffff", bus.result_o);
    else passCount++;
    release_result();
  endtask

  task automatic test_annul();
    int rc, sl;
    do_div(1'b0, 32'd1000, 32'd3, 10, 45, rc, sl);
    totalCount++;
    if (rc !== -1) $display("FAIL annul_ready: ready seen at cycle %0d want never", rc);
    else passCount++;
    totalCount++;
    if (sl !== 11) $display("FAIL annul_stall: stall first low at %0d want 11", sl);
    else passCount++;
    totalCount++;
    if (bus.result_o !== lastResult) $display("FAIL annul_result_kept: got %h want %h", bus.result_o, lastResult);
    else passCount++;
  endtask

  task automatic test_hold();
    int rc, sl;
    logic [2*W-1:0] exp;
    sbQ.push_back(model(1'b1, -32'sd100, 32'd7));
    do_div(1'b1, -32'sd100, 32'd7, -1, 60, rc, sl);
    exp = sbQ.pop_front();
    lastResult = exp;
    totalCount++;
    if (bus.result_o !== exp) $display("FAIL hold_result: got %h want %h", bus.result_o, exp);
    else passCount++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      totalCount++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== exp)
        $display("FAIL hold_stable[%0d]: ready=%b result=%h want 1 %h", i, bus.ready_o, bus.result_o, exp);
      else passCount++;
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int rc, sl;
    logic [2*W-1:0] exp;
    sbQ.push_back(model(1'b0, 32'd9, 32'd3));
    do_div(1'b0, 32'd9, 32'd3, -1, 60, rc, sl);
    exp = sbQ.pop_front();
    totalCount++;
    if (bus.result_o !== {32'd0, 32'd3}) $display("FAIL b2b_first: got %h want 00000000_00000003", bus.result_o);
    else passCount++;
    totalCount++;
    if (bus.result_o !== exp) $display("FAIL b2b_first_sb: got %h want %h", bus.result_o, exp);
    else passCount++;
    bus.advance_i = 1'b1;
    bus.start_i   = 1'b1;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd10;
    bus.opdata2_i = 32'd4;
    #1;
    totalCount++;
    if (bus.stall_o !== 1'b0) $display("FAIL b2b_end_stall: got %b want 0", bus.stall_o);
    else passCount++;
    sbQ.push_back(model(1'b0, 32'd10, 32'd4));
    do_div(1'b0, 32'd10, 32'd4, -1, 60, rc, sl);
    totalCount++;
    if (rc !== 33) $display("FAIL b2b_second_latency: got %0d want 33 after bubble", rc);
    else passCount++;
    totalCount++;
    if (sl !== 33) $display("FAIL b2b_second_stall: stall first low at %0d want 33", sl);
    else passCount++;
    exp = sbQ.pop_front();
    lastResult = exp;
    totalCount++;
    if (bus.result_o !== {32'd2, 32'd2}) $display("FAIL b2b_second: got %h want 00000002_00000002", bus.result_o);
    else passCount++;
    release_result();
  endtask

  task automatic test_shortcut();
    int rc, sl;
    int wantLat;
    logic [2*W-1:0] exp;
`ifdef DIV_SHORTCUT_EN
    wantLat = 2;
`else
    wantLat = 33;
`endif
    sbQ.push_back(model(1'b0, 32'd3, 32'd10));
    do_div(1'b0, 32'd3, 32'd10, -1, 60, rc, sl);
    totalCount++;
    if (rc !== wantLat) $display("FAIL shortcut_latency: got %0d want %0d", rc, wantLat);
    else passCount++;
    exp = sbQ.pop_front();
    totalCount++;
    if (bus.result_o !== {32'd3, 32'd0}) $display("FAIL shortcut_result: got %h want 00000003_00000000", bus.result_o);
    else passCount++;
    totalCount++;
    if (bus.result_o !== exp) $display("FAIL shortcut_result_sb: got %h want %h", bus.result_o, exp);
    else passCount++;
    release_result();
    sbQ.push_back(model(1'b1, 32'hFFFF_FFFD, 32'd10));
    do_div(1'b1, 32'hFFFF_FFFD, 32'd10, -1, 60, rc, sl);
    exp = sbQ.pop_front();
    totalCount++;
    if (bus.result_o !== exp || exp[HI_MSB:HI_LSB] !== 32'hFFFF_FFFD || exp[LO_MSB:LO_LSB] !== 32'd0)
      $display("FAIL shortcut_signed: got %h want fffffffd_00000000", bus.result_o);
    else passCount++;
    release_result();
  endtask

  initial begin
    rst           = 1'b1;
    bus.start_i   = 1'b0;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.annul_i   = 1'b0;
    bus.advance_i = 1'b0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_annul();
    test_hold();
    test_back_to_back();
    test_shortcut();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
